// File: rtl/pwm_compare_stage.sv
// PWM compare stage: double-buffered duty compare against the free-running
// count, driving complementary high/low-side outputs with programmable dead-time.
module pwm_compare_stage #(
   parameter int n    = 8,
   parameter int DT_W = 4
) (
   input  logic            in_clk,
   input  logic            in_nres,
   input  logic [n-1:0]    in_count,
   input  logic            in_done,
   input  logic            in_enable,
   input  logic [n-1:0]    in_duty,
   input  logic            in_duty_valid,
   output logic            out_duty_ready,
   input  logic [DT_W-1:0] in_deadtime,
   output logic            out_pwm_h,
   output logic            out_pwm_l,
   output logic            out_period_start,
   output logic [n-1:0]    out_duty_active
);

   typedef enum logic [2:0] {
      IDLE,
      H_ON,
      L_ON,
      DT_TO_H,
      DT_TO_L
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [DT_W-1:0] dt_cnt;
   logic [DT_W-1:0] dt_cnt_nxt;
   logic            pending_full;
   logic [n-1:0]    pending;
   logic            raw_q;
   logic            handshake;

   assign out_duty_ready = ~pending_full;
   assign handshake      = in_duty_valid & out_duty_ready;

   // A new duty value only reaches the comparator at a period boundary.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge in_clk or negedge in_nres) begin
      if (!in_nres) begin
         pending_full    <= 1'b0;
         pending         <= '0;
         out_duty_active <= '0;
      end else if (in_done && pending_full) begin
         out_duty_active <= pending;
         pending_full    <= 1'b0;
      end else if (handshake) begin
         pending      <= in_duty;
         pending_full <= 1'b1;
      end
   end

   always_ff @(posedge in_clk or negedge in_nres) begin
      if (!in_nres) begin
         raw_q            <= 1'b0;
         out_period_start <= 1'b0;
      end else begin
         raw_q            <= (in_count < out_duty_active);
         out_period_start <= in_done;
      end
   end

   always_ff @(posedge in_clk or negedge in_nres) begin
      if (!in_nres) begin
         state  <= IDLE;
         dt_cnt <= '0;
      end else begin
         state  <= state_nxt;
         dt_cnt <= dt_cnt_nxt;
      end
   end

   // NOTE: hold-current defaults make every path assign both outputs, so no latch is inferred.
   always_comb begin
      state_nxt  = state;
      dt_cnt_nxt = dt_cnt;
      if (!in_enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: state_nxt = raw_q ? H_ON : L_ON;
            L_ON: begin
               if (raw_q) begin
                  if (in_deadtime == '0) begin
                     state_nxt = H_ON;
                  end else begin
                     state_nxt  = DT_TO_H;
                     dt_cnt_nxt = in_deadtime - DT_W'(1);
                  end
               end
            end
            H_ON: begin
               if (!raw_q) begin
                  if (in_deadtime == '0) begin
                     state_nxt = L_ON;
                  end else begin
                     state_nxt  = DT_TO_L;
                     dt_cnt_nxt = in_deadtime - DT_W'(1);
                  end
               end
            end
            // A compare reversal during dead-time returns to the side still safely off.
            DT_TO_H: begin
               if (!raw_q)              state_nxt  = L_ON;
               else if (dt_cnt == '0)   state_nxt  = H_ON;
               else                     dt_cnt_nxt = dt_cnt - DT_W'(1);
            end
            DT_TO_L: begin
               if (raw_q)               state_nxt  = H_ON;
               else if (dt_cnt == '0)   state_nxt  = L_ON;
               else                     dt_cnt_nxt = dt_cnt - DT_W'(1);
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      out_pwm_h = 1'b0;
      out_pwm_l = 1'b0;
      case (state)
         H_ON:    out_pwm_h = 1'b1;
         L_ON:    out_pwm_l = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/pwm_compare_stage.md
Name: pwm_compare_stage

Overview:
- Downstream consumer of n_bit_counter in the PWM controller.
- Compares the free-running count against a double-buffered duty value and produces complementary high-side/low-side PWM outputs with programmable dead-time.
- New duty values arrive over a valid/ready handshake. They take effect only at a period boundary, signalled by the counter's done pulse.

Parameters:
- n, 8: width of count and duty values.
- DT_W, 4: width of the dead-time setting.

Ports:
- in_clk  input  1  system clock; all state updates on its rising edge
- in_nres  input  1  asynchronous active-low reset
- in_count  input  n  current counter value from n_bit_counter
- in_done  input  1  one-cycle period-boundary pulse from n_bit_counter
- in_enable  input  1  output enable; 0 forces both outputs low
- in_duty  input  n  requested duty (high-side on-count)
- in_duty_valid  input  1  in_duty is valid
- out_duty_ready  output  1  stage can accept a new duty value
- in_deadtime  input  DT_W  dead-time in clock cycles
- out_pwm_h  output  1  high-side drive
- out_pwm_l  output  1  low-side drive
- out_period_start  output  1  registered copy of in_done
- out_duty_active  output  n  duty value currently applied

Behaviour:
- Reset (in_nres low, asynchronous, takes effect immediately):
  - Outputs: out_pwm_h=0, out_pwm_l=0, out_duty_ready=1, out_duty_active=0, out_period_start=0.
  - Internal: pending register empty, compare register raw_q=0, FSM=IDLE.
- Duty buffering:
  - Handshake fires when in_duty_valid & out_duty_ready at a clock edge; in_duty is captured into the pending register and out_duty_ready=0 from the next cycle.
  - On in_done with pending full: out_duty_active<=pending, pending cleared, out_duty_ready=1 the next cycle.
  - Handshake and in_done in the same cycle with pending empty: the value is captured to pending only. It applies at the following in_done.
  - in_done with pending empty: active unchanged.
  - in_duty_valid while ready=0: ignored; the sender holds its value.
- Compare:
  - raw_q <= (in_count < out_duty_active), unsigned, n bits, registered once.
  - Duty 0 means high side never on. Duty 2^n-1 means high for every count except 2^n-1; full-on is not supported.
- out_period_start <= in_done each cycle, independent of in_enable.
- Output FSM states: IDLE, H_ON, L_ON, DT_TO_H, DT_TO_L. A dead-time down-counter dt_cnt is DT_W bits.
  - IDLE (h=0, l=0):
    - in_enable=1 -> H_ON if raw_q, else L_ON (no dead-time needed, both already off).
  - L_ON (h=0, l=1): raw_q=1 ->
    - DT_TO_H with dt_cnt=in_deadtime-1 if in_deadtime!=0.
    - H_ON directly if in_deadtime==0.
  - H_ON (h=1, l=0): raw_q=0 -> DT_TO_L, or L_ON directly; same rule as L_ON.
  - DT_TO_H (h=0, l=0):
    - dt_cnt==0 -> H_ON; otherwise decrement.
    - raw_q returns to 0 -> L_ON next cycle (abort; high side never drove).
  - DT_TO_L (h=0, l=0): symmetric to DT_TO_H; abort target is H_ON.
  - Any state with in_enable=0 -> IDLE next cycle. This has priority over all other transitions.
- Dead-time timing:
  - Dead-time interval is exactly in_deadtime cycles with both outputs low.
  - in_deadtime is sampled only on dead-state entry; changes mid-interval have no effect.
- Outputs decode registered FSM state (glitch-free). h and l are never both 1.
- Latency: a count edge in cycle 0 gives raw_q change at cycle 1. The dead state begins at cycle 2, and the new side turns on at cycle 2+in_deadtime.
- Reset asserted mid-operation: both outputs low immediately; the pending value is discarded.

Test Plan:
- Reset, enable=1, no duty load, counter sweeping 0..255 -> out_duty_active=0, out_pwm_h always 0, out_pwm_l=1 from second cycle after enable, out_duty_ready=1.
- Handshake duty=64 at count 100 -> out_duty_ready=0 next cycle; out_duty_active stays 0 until in_done, then becomes 64; ready returns 1. Next period: out_pwm_h high from count 0+2+dt through count 63+2 (offset 2 cycles); out_pwm_l low while h high.
- in_deadtime=3, duty=64 -> at each transition both outputs low exactly 3 cycles; h and l never both 1 over 10 periods.
- in_deadtime=5, force in_count so raw flips 1 then back to 0 after 2 cycles (while in DT_TO_H) -> FSM returns to L_ON. out_pwm_h never asserts; l low exactly 2 cycles.
- Load 32 then hold valid with duty=200 while ready=0 -> second value accepted the cycle after in_done. 32 applies period k+1, 200 applies period k+2.
- Deassert in_nres asynchronously mid-H_ON (between clock edges) -> out_pwm_h=0 immediately, out_duty_active=0, out_duty_ready=1. After release with enable=1: enters L_ON.
